stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Sequencer and arbiter in front of the 32-bit hardware stack, shared by the CPU PUSH/POP path and the interrupt context unit.
- The CPU gets single-word push/pop.
- The interrupt unit gets atomic multi-word context save and restore bursts.
- The block keeps a shadow depth counter, gates every operation against full/empty, stalls the CPU while a burst owns the stack, and records sticky overflow/underflow errors.

Parameters:
- DW, 32, data word width
- DEPTH, 1024, stack capacity in words
- CTX_WORDS, 4, words per context save/restore burst (2..16)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cpu_push  in  1  CPU push request, single cycle
- cpu_pop  in  1  CPU pop request, single cycle
- cpu_wdata  in  DW  CPU push data
- cpu_rdata  out  DW  top-of-stack as seen by the CPU (stk_rdata pass-through)
- cpu_stall  out  1  CPU must hold its request; the request is not executed
- ctx_save_req  in  1  context save request, level; sampled only in IDLE
- ctx_restore_req  in  1  context restore request, level; sampled only in IDLE
- ctx_wdata  in  CTX_WORDS*DW  context words; word 0 in LSBs
- ctx_rdata  out  CTX_WORDS*DW  restored context, registered
- ctx_done  out  1  one-cycle pulse when a burst completes or is rejected
- ctx_busy  out  1  burst in progress
- stk_push  out  1  push strobe to the stack
- stk_pop  out  1  pop strobe to the stack
- stk_wdata  out  DW  data to the stack
- stk_rdata  in  DW  combinational top-of-stack from the stack
- depth  out  $clog2(DEPTH)+1  current word count
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- ovf_err  out  1  sticky overflow/reject flag
- unf_err  out  1  sticky underflow/reject flag
- err_clr  in  1  clears both sticky flags

Behaviour:
- Reset state:
  - State IDLE; depth=0; ctx_rdata=0; ovf_err/unf_err=0; ctx_done=0.
  - stk_push/stk_pop=0; cpu_stall=0.
- FSM states: IDLE, SAVE, RESTORE, DONE. Beat counter is $clog2(CTX_WORDS) bits wide.
- IDLE:
  - Priority is save > restore > CPU.
  - Save is accepted when depth <= DEPTH-CTX_WORDS.
    - If accepted: go to SAVE, latch ctx_wdata, beat=0, assert cpu_stall this cycle.
    - Otherwise: set ovf_err, pulse ctx_done next cycle via DONE; no stack access.
  - Restore is accepted when depth >= CTX_WORDS.
    - If accepted: go to RESTORE.
    - Otherwise: set unf_err, go to DONE.
  - CPU push when not full: stk_push=1, stk_wdata=cpu_wdata, depth+1.
  - CPU push when full: no strobe; set ovf_err.
  - CPU pop when not empty: stk_pop=1, depth-1.
  - CPU pop when empty: no strobe; set unf_err.
  - cpu_push & cpu_pop together: no-op, no error.
- SAVE:
  - Each cycle: stk_push=1, stk_wdata=latched word[beat], depth+1, beat+1.
  - After beat CTX_WORDS-1, go to DONE.
- RESTORE:
  - Each cycle: stk_pop=1, depth-1.
  - Capture stk_rdata into ctx_rdata word[CTX_WORDS-1-beat], so the save order is reproduced.
  - After the last beat, go to DONE.
- DONE: ctx_done=1 for one cycle, then IDLE.
- Stall and busy:
  - cpu_stall=1 in SAVE, RESTORE and DONE, and in IDLE whenever a ctx request is present.
  - ctx_busy=1 in SAVE, RESTORE and DONE.
- Latency: an accepted burst issues CTX_WORDS strobes in cycles T+1..T+CTX_WORDS; ctx_done is at T+CTX_WORDS+1.
- Strobe exclusivity: never more than one strobe per cycle; stk_push and stk_pop are never both high.
- Depth bounds: depth stays within [0, DEPTH]; bursts are never partial.
- err_clr: clears the flags; a new error in the same cycle wins.
- Reset mid-burst: returns to IDLE with depth=0. Stack contents are abandoned, and the stack must be reset by the same rst.

Decomposition:
- Package stack_pkg holds the state enum (IDLE/SAVE/RESTORE/DONE) and the DEPTH/DW defaults.
- One sub-module, stack_depth_ctr: the depth up/down counter with full/empty flags.

Test Plan:
- Push 0xA5A5_0001 then pop, idle otherwise -> stk_push pulses once, depth 0→1→0; cpu_rdata=0xA5A5_0001 before the pop.
- Context save of {3,2,1,0} with depth=5 -> stk_push high 4 cycles with data 0,1,2,3; depth=9; ctx_done at T+5; cpu_stall high T..T+5.
- Restore after that save -> 4 pops; ctx_rdata={3,2,1,0} (word 0 = 0); depth=5.
- depth=1022 with CTX_WORDS=4, save requested -> no stk_push, ovf_err=1, ctx_done pulse at T+1, depth unchanged; err_clr clears the flag.
- Pop at empty, and push when full after 1024 pushes -> unf_err=1 and ovf_err=1 respectively; no strobes; depth stays 0 / 1024.
- cpu_push and ctx_save_req asserted in the same cycle -> save wins, CPU stalled until ctx_done; the held push executes the cycle after DONE; final depth = 5.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants for the stack sequencer: FSM state encodings and default geometry.
package stack_pkg;

  localparam int unsigned DW_DEF        = 32;
  localparam int unsigned DEPTH_DEF     = 1024;
  localparam int unsigned CTX_WORDS_DEF = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAVE    = 2'd1;
  localparam logic [1:0] ST_RESTORE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/stack_depth_ctr.sv
// Shadow word counter for the hardware stack with full/empty decode.
module stack_depth_ctr
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     dec,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;

  logic [DEPTH_W-1:0] depth_q;
  logic [DEPTH_W-1:0] depth_d;

  always_comb begin
    depth_d = depth_q;
    if (inc && !dec) begin
      depth_d = depth_q + DEPTH_W'(1);
    end else if (dec && !inc) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else begin
      depth_q <= depth_d;
    end
  end

  assign depth = depth_q;
  assign full  = (depth_q == DEPTH_W'(DEPTH));
  assign empty = (depth_q == '0);

endmodule

// File: rtl/stack_ctrl.sv
// Arbiter/sequencer in front of the hardware stack: CPU single-word push/pop
// and atomic interrupt context save/restore bursts, with sticky error flags.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned CTX_WORDS = CTX_WORDS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_push,
  input  logic                      cpu_pop,
  input  logic [DW-1:0]             cpu_wdata,
  output logic [DW-1:0]             cpu_rdata,
  output logic                      cpu_stall,
  input  logic                      ctx_save_req,
  input  logic                      ctx_restore_req,
  input  logic [CTX_WORDS*DW-1:0]   ctx_wdata,
  output logic [CTX_WORDS*DW-1:0]   ctx_rdata,
  output logic                      ctx_done,
  output logic                      ctx_busy,
  output logic                      stk_push,
  output logic                      stk_pop,
  output logic [DW-1:0]             stk_wdata,
  input  logic [DW-1:0]             stk_rdata,
  output logic [$clog2(DEPTH):0]    depth,
  output logic                      full,
  output logic                      empty,
  output logic                      ovf_err,
  output logic                      unf_err,
  input  logic                      err_clr
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH) + 1;
  localparam int unsigned BEAT_W  = $clog2(CTX_WORDS);
  localparam int unsigned CTX_W   = CTX_WORDS * DW;

  logic [1:0]        state_q,     state_d;
  logic [BEAT_W-1:0] beat_q,      beat_d;
  logic [CTX_W-1:0]  ctx_buf_q,   ctx_buf_d;
  logic [CTX_W-1:0]  ctx_rdata_q, ctx_rdata_d;
  logic              ovf_err_q,   ovf_err_d;
  logic              unf_err_q,   unf_err_d;
  logic              cnt_inc, cnt_dec;
  logic              ovf_set, unf_set;
  logic              last_beat;

  stack_depth_ctr #(.DEPTH(DEPTH)) u_depth (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc),
    .dec   (cnt_dec),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  assign last_beat = (beat_q == BEAT_W'(CTX_WORDS - 1));

  // Next-state, strobe and capture logic; only one strobe source per state.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    ctx_buf_d   = ctx_buf_q;
    ctx_rdata_d = ctx_rdata_q;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    stk_wdata   = cpu_wdata;
    cnt_inc     = 1'b0;
    cnt_dec     = 1'b0;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    cpu_stall   = 1'b0;
    ctx_busy    = 1'b0;
    ctx_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cpu_stall = ctx_save_req | ctx_restore_req;
        if (ctx_save_req) begin
          if (depth <= DEPTH_W'(DEPTH - CTX_WORDS)) begin
            state_d   = ST_SAVE;
            ctx_buf_d = ctx_wdata;
            beat_d    = '0;
          end else begin
            ovf_set = 1'b1;
            state_d = ST_DONE;
          end
        end else if (ctx_restore_req) begin
          if (depth >= DEPTH_W'(CTX_WORDS)) begin
            state_d = ST_RESTORE;
            beat_d  = '0;
          end else begin
            unf_set = 1'b1;
            state_d = ST_DONE;
          end
        end else if (cpu_push && !cpu_pop) begin
          if (!full) begin
            stk_push = 1'b1;
            cnt_inc  = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
        end else if (cpu_pop && !cpu_push) begin
          if (!empty) begin
            stk_pop = 1'b1;
            cnt_dec = 1'b1;
          end else begin
            unf_set = 1'b1;
          end
        end
      end
      ST_SAVE: begin
        cpu_stall = 1'b1;
        ctx_busy  = 1'b1;
        stk_push  = 1'b1;
        stk_wdata = ctx_buf_q[32'(beat_q)*DW +: DW];
        cnt_inc   = 1'b1;
        beat_d    = beat_q + BEAT_W'(1);
        if (last_beat) state_d = ST_DONE;
      end
      ST_RESTORE: begin
        cpu_stall = 1'b1;
        ctx_busy  = 1'b1;
        stk_pop   = 1'b1;
        cnt_dec   = 1'b1;
        // Top of stack is the last saved word, so fill from the high word down.
        ctx_rdata_d[(CTX_WORDS - 1 - 32'(beat_q))*DW +: DW] = stk_rdata;
        beat_d    = beat_q + BEAT_W'(1);
        if (last_beat) state_d = ST_DONE;
      end
      ST_DONE: begin
        cpu_stall = 1'b1;
        ctx_busy  = 1'b1;
        ctx_done  = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ovf_err_d = ovf_set | (ovf_err_q & ~err_clr);
  assign unf_err_d = unf_set | (unf_err_q & ~err_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      ctx_buf_q   <= '0;
      ctx_rdata_q <= '0;
      ovf_err_q   <= 1'b0;
      unf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      ctx_buf_q   <= ctx_buf_d;
      ctx_rdata_q <= ctx_rdata_d;
      ovf_err_q   <= ovf_err_d;
      unf_err_q   <= unf_err_d;
    end
  end

  assign cpu_rdata = stk_rdata;
  assign ctx_rdata = ctx_rdata_q;
  assign ovf_err   = ovf_err_q;
  assign unf_err   = unf_err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural stack memory attached.
module tb_stack_ctrl;

  localparam int unsigned DW        = 32;
  localparam int unsigned DEPTH     = 1024;
  localparam int unsigned CTX_WORDS = 4;
  localparam int unsigned DEPTH_W   = $clog2(DEPTH) + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cpu_push, cpu_pop;
  logic [DW-1:0]           cpu_wdata, cpu_rdata;
  logic                    cpu_stall;
  logic                    ctx_save_req, ctx_restore_req;
  logic [CTX_WORDS*DW-1:0] ctx_wdata, ctx_rdata;
  logic                    ctx_done, ctx_busy;
  logic                    stk_push, stk_pop;
  logic [DW-1:0]           stk_wdata, stk_rdata;
  logic [DEPTH_W-1:0]      depth;
  logic                    full, empty, ovf_err, unf_err, err_clr;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]      mem [DEPTH];
  logic [DEPTH_W-1:0] sp;

  always #5 clk = ~clk;

  stack_ctrl #(.DW(DW), .DEPTH(DEPTH), .CTX_WORDS(CTX_WORDS)) dut (
    .clk(clk), .rst(rst),
    .cpu_push(cpu_push), .cpu_pop(cpu_pop), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ctx_save_req(ctx_save_req), .ctx_restore_req(ctx_restore_req),
    .ctx_wdata(ctx_wdata), .ctx_rdata(ctx_rdata),
    .ctx_done(ctx_done), .ctx_busy(ctx_busy),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata), .depth(depth), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(err_clr)
  );

  // Behavioural stack: combinational top-of-stack, reset with the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (stk_push && !stk_pop && sp < DEPTH_W'(DEPTH)) begin
      mem[sp[DEPTH_W-2:0]] <= stk_wdata;
      sp <= sp + DEPTH_W'(1);
    end else if (stk_pop && !stk_push && sp != '0) begin
      sp <= sp - DEPTH_W'(1);
    end
  end

  always_comb begin
    stk_rdata = '0;
    if (sp != '0) stk_rdata = mem[sp[DEPTH_W-2:0] - (DEPTH_W-1)'(1)];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    cpu_push = 0; cpu_pop = 0; cpu_wdata = '0;
    ctx_save_req = 0; ctx_restore_req = 0; ctx_wdata = '0; err_clr = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_depth", 128'(depth), 128'd0);
    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_full", 128'(full), 128'd0);
    chk("rst_strobes", 128'({stk_push, stk_pop}), 128'd0);
    chk("rst_stall", 128'(cpu_stall), 128'd0);
    chk("rst_done_busy", 128'({ctx_done, ctx_busy}), 128'd0);
    chk("rst_errs", 128'({ovf_err, unf_err}), 128'd0);
    chk("rst_ctx_rdata", 128'(ctx_rdata), 128'd0);

    // Single push then pop.
    tick();
    cpu_push = 1; cpu_wdata = 32'hA5A5_0001; #1;
    chk("push_strobe", 128'(stk_push), 128'd1);
    chk("push_wdata", 128'(stk_wdata), 128'hA5A5_0001);
    tick();
    cpu_push = 0; #1;
    chk("push_depth", 128'(depth), 128'd1);
    chk("push_rdata", 128'(cpu_rdata), 128'hA5A5_0001);
    chk("push_once", 128'(stk_push), 128'd0);
    cpu_pop = 1; #1;
    chk("pop_strobe", 128'(stk_pop), 128'd1);
    tick();
    cpu_pop = 0; #1;
    chk("pop_depth", 128'(depth), 128'd0);

    // Fill to depth 5 with 0x10..0x14; push&pop together is a no-op.
    for (int i = 0; i < 5; i++) begin
      cpu_push = 1; cpu_wdata = 32'h10 + 32'(i);
      tick();
    end
    cpu_push = 1; cpu_pop = 1; #1;
    chk("pushpop_nostrobe", 128'({stk_push, stk_pop}), 128'd0);
    tick();
    cpu_push = 0; cpu_pop = 0; #1;
    chk("pushpop_depth", 128'(depth), 128'd5);
    chk("pushpop_noerr", 128'({ovf_err, unf_err}), 128'd0);

    // Context save of {3,2,1,0} at depth 5.
    ctx_wdata = {32'd3, 32'd2, 32'd1, 32'd0};
    ctx_save_req = 1; #1;
    chk("save_T_stall", 128'(cpu_stall), 128'd1);
    chk("save_T_nopush", 128'(stk_push), 128'd0);
    tick();
    ctx_save_req = 0; ctx_wdata = '1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("save_push", 128'(stk_push), 128'd1);
      chk("save_wdata", 128'(stk_wdata), 128'(i));
      chk("save_stall", 128'({cpu_stall, ctx_busy, ctx_done}), 128'b110);
      tick();
    end
    #1;
    chk("save_done", 128'(ctx_done), 128'd1);
    chk("save_done_stall", 128'(cpu_stall), 128'd1);
    chk("save_done_nopush", 128'(stk_push), 128'd0);
    chk("save_depth", 128'(depth), 128'd9);
    tick();
    chk("save_after", 128'({ctx_done, cpu_stall, ctx_busy}), 128'd0);

    // Restore reproduces the saved words.
    ctx_restore_req = 1; #1;
    chk("rest_T_stall", 128'(cpu_stall), 128'd1);
    tick();
    ctx_restore_req = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rest_pop", 128'({stk_pop, stk_push}), 128'b10);
      tick();
    end
    #1;
    chk("rest_done", 128'(ctx_done), 128'd1);
    chk("rest_rdata", 128'(ctx_rdata), {32'd3, 32'd2, 32'd1, 32'd0});
    chk("rest_depth", 128'(depth), 128'd5);
    chk("rest_tos", 128'(cpu_rdata), 128'h14);
    tick();

    // Save rejected at depth 1022.
    for (int i = 0; i < 1017; i++) begin
      cpu_push = 1; cpu_wdata = 32'(i);
      tick();
    end
    cpu_push = 0; #1;
    chk("fill_depth", 128'(depth), 128'd1022);
    ctx_save_req = 1; #1;
    chk("rej_T_nopush", 128'(stk_push), 128'd0);
    chk("rej_T_stall", 128'(cpu_stall), 128'd1);
    tick();
    ctx_save_req = 0; #1;
    chk("rej_done", 128'(ctx_done), 128'd1);
    chk("rej_ovf", 128'(ovf_err), 128'd1);
    chk("rej_nopush", 128'(stk_push), 128'd0);
    chk("rej_depth", 128'(depth), 128'd1022);
    tick();
    err_clr = 1;
    tick();
    err_clr = 0; #1;
    chk("clr_ovf", 128'(ovf_err), 128'd0);

    // Push to full, then push at full.
    for (int i = 0; i < 2; i++) begin
      cpu_push = 1; cpu_wdata = 32'hF0 + 32'(i);
      tick();
    end
    #1;
    chk("full_flag", 128'(full), 128'd1);
    chk("full_depth", 128'(depth), 128'd1024);
    chk("full_noovf", 128'(ovf_err), 128'd0);
    #1;
    chk("full_nostrobe", 128'(stk_push), 128'd0);
    tick();
    cpu_push = 0; #1;
    chk("full_ovf", 128'(ovf_err), 128'd1);
    chk("full_depth2", 128'(depth), 128'd1024);
    err_clr = 1;
    tick();
    err_clr = 0;

    // Drain, then pop at empty; error set during err_clr still wins.
    for (int i = 0; i < 1024; i++) begin
      cpu_pop = 1;
      tick();
    end
    #1;
    chk("drain_empty", 128'(empty), 128'd1);
    chk("empty_nostrobe", 128'(stk_pop), 128'd0);
    tick();
    cpu_pop = 0; #1;
    chk("empty_unf", 128'(unf_err), 128'd1);
    chk("empty_depth", 128'(depth), 128'd0);
    cpu_pop = 1; err_clr = 1;
    tick();
    cpu_pop = 0; err_clr = 0; #1;
    chk("clr_vs_set", 128'(unf_err), 128'd1);
    err_clr = 1;
    tick();
    err_clr = 0; #1;
    chk("clr_unf", 128'(unf_err), 128'd0);

    // Restore rejected when empty.
    ctx_restore_req = 1;
    tick();
    ctx_restore_req = 0; #1;
    chk("rrej_done", 128'({ctx_done, unf_err}), 128'b11);
    chk("rrej_nopop", 128'(stk_pop), 128'd0);
    tick();
    err_clr = 1;
    tick();
    err_clr = 0;

    // Push collides with save: save wins, push held until after DONE.
    ctx_wdata = {32'd7, 32'd6, 32'd5, 32'd4};
    ctx_save_req = 1; cpu_push = 1; cpu_wdata = 32'h77; #1;
    chk("col_T_stall", 128'(cpu_stall), 128'd1);
    chk("col_T_nopush", 128'(stk_push), 128'd0);
    tick();
    ctx_save_req = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("col_stall", 128'(cpu_stall), 128'd1);
      tick();
    end
    #1;
    chk("col_release", 128'(cpu_stall), 128'd0);
    chk("col_push", 128'(stk_push), 128'd1);
    chk("col_wdata", 128'(stk_wdata), 128'h77);
    tick();
    cpu_push = 0; #1;
    chk("col_depth", 128'(depth), 128'd5);
    chk("col_tos", 128'(cpu_rdata), 128'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
